// File: rtl/dma_ctrl_pkg.sv
// dma_ctrl_pkg
//   Shared definitions for the GN4124 DMA register front-end: register word
//   offsets, CTRL/STATUS bit positions, the sequencer state type and the
//   mapping from internal state to the code reported in STATUS[2:0].
package dma_ctrl_pkg;

    localparam logic [3:0] c_DMA_CTRL    = 4'd0;
    localparam logic [3:0] c_DMA_STATUS  = 4'd1;
    localparam logic [3:0] c_DMA_CSTART  = 4'd2;
    localparam logic [3:0] c_DMA_HSTARTL = 4'd3;
    localparam logic [3:0] c_DMA_HSTARTH = 4'd4;
    localparam logic [3:0] c_DMA_LEN     = 4'd5;
    localparam logic [3:0] c_DMA_NEXTL   = 4'd6;
    localparam logic [3:0] c_DMA_NEXTH   = 4'd7;
    localparam logic [3:0] c_DMA_ATTRIB  = 4'd8;

    localparam int unsigned c_CTRL_START_BIT = 0;
    localparam int unsigned c_CTRL_ABORT_BIT = 1;
    localparam int unsigned c_ATTRIB_DIR_BIT = 0;

    localparam logic [31:0] c_STATUS_CLR_MASK = 32'h0000_0004;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DONE     = 3'd1,
        BUSY     = 3'd2,
        ERROR    = 3'd3,
        ABORTED  = 3'd4,
        ABORTING = 3'd5
    } t_dma_state;

    // ABORTING is invisible to software: it reads as BUSY until the mover
    // acknowledges the abort.
    function automatic logic [2:0] status_code(input t_dma_state s);
        logic [2:0] code;
        code = (s == ABORTING) ? 3'd2 : 3'(s);
        return code;
    endfunction

endpackage

// File: rtl/dma_ctrl_fsm.sv
// dma_ctrl_fsm
//   Transfer sequencer: validates the programmed configuration on start,
//   issues the one-cycle command pulse, tracks done/error/abort/timeout and
//   owns the done/error interrupt flops.
//   Ports:
//     clk_i, rst_n_i          clock, async active-low reset
//     start_req/abort_req/clr_req  one-cycle requests decoded from the bus
//     cstart, len             carrier address and length to validate
//     xfer_done_i/xfer_error_i  completion pulses from the mover
//     state                   current sequencer state
//     xfer_start/xfer_abort   command outputs to the mover (registered)
//     irq_done/irq_error      level interrupts (registered)
module dma_ctrl_fsm
    import dma_ctrl_pkg::*;
#(
    parameter int unsigned g_TIMEOUT    = 2**20,
    parameter int unsigned g_ADDR_ALIGN = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_req,
    input  logic        abort_req,
    input  logic        clr_req,
    input  logic [31:0] cstart,
    input  logic [31:0] len,
    input  logic        xfer_done_i,
    input  logic        xfer_error_i,
    output t_dma_state  state,
    output logic        xfer_start,
    output logic        xfer_abort,
    output logic        irq_done,
    output logic        irq_error
);

    // Alignment is a power of two, so a mask test replaces the modulo.
    localparam logic [31:0] c_ALIGN_MASK = 32'(g_ADDR_ALIGN - 1);

    logic [31:0] tmo_cnt;
    logic        cfg_ok;

    assign cfg_ok = (len != '0) && ((len & c_ALIGN_MASK) == '0)
                 && ((cstart & c_ALIGN_MASK) == '0);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= IDLE;
            xfer_start <= 1'b0;
            xfer_abort <= 1'b0;
            irq_done   <= 1'b0;
            irq_error  <= 1'b0;
            tmo_cnt    <= '0;
        end else begin
            xfer_start <= 1'b0;
            // Clear first; any event below overrides it in the same cycle.
            if (clr_req) begin
                irq_done  <= 1'b0;
                irq_error <= 1'b0;
            end
            case (state)
                IDLE, DONE, ERROR, ABORTED: begin
                    xfer_abort <= 1'b0;
                    if (start_req) begin
                        if (!cfg_ok) begin
                            state     <= ERROR;
                            irq_error <= 1'b1;
                        end else begin
                            state      <= BUSY;
                            xfer_start <= 1'b1;
                            irq_done   <= 1'b0;
                            irq_error  <= 1'b0;
                            tmo_cnt    <= 32'(g_TIMEOUT);
                        end
                    end else if (clr_req) begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    if (tmo_cnt != '0)
                        tmo_cnt <= tmo_cnt - 32'd1;
                    if (xfer_error_i) begin
                        state     <= ERROR;
                        irq_error <= 1'b1;
                    end else if (xfer_done_i) begin
                        state    <= DONE;
                        irq_done <= 1'b1;
                    end else if ((g_TIMEOUT != 0) && (tmo_cnt <= 32'd1)) begin
                        // Counter hits 0 on this edge; kick the mover once.
                        state      <= ERROR;
                        irq_error  <= 1'b1;
                        xfer_abort <= 1'b1;
                    end else if (abort_req) begin
                        state      <= ABORTING;
                        xfer_abort <= 1'b1;
                    end
                end
                ABORTING: begin
                    if (xfer_done_i || xfer_error_i) begin
                        state      <= ABORTED;
                        xfer_abort <= 1'b0;
                        irq_error  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/dma_ctrl_regs.sv
// dma_ctrl_regs
//   Wishbone register front-end for the GN4124 DMA path (DMA_BASE 0x00C0).
//   Holds the transfer descriptor registers, decodes CTRL/STATUS writes into
//   requests for dma_ctrl_fsm and mirrors the registers onto xfer_*.
//   Ports:
//     clk_i, rst_n_i                 clock, async active-low reset
//     wb_*                           classic single-cycle Wishbone slave
//     xfer_*_o                       command/descriptor outputs to the mover
//     xfer_done_i, xfer_error_i      completion pulses from the mover
//     irq_done_o, irq_error_o        level interrupts into the VIC
module dma_ctrl_regs
    import dma_ctrl_pkg::*;
#(
    parameter int unsigned g_TIMEOUT    = 2**20,
    parameter int unsigned g_ADDR_ALIGN = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        xfer_start_o,
    output logic        xfer_dir_o,
    output logic [31:0] xfer_carrier_addr_o,
    output logic [63:0] xfer_host_addr_o,
    output logic [31:0] xfer_len_o,
    output logic [63:0] xfer_next_o,
    output logic        xfer_abort_o,
    input  logic        xfer_done_i,
    input  logic        xfer_error_i,
    output logic        irq_done_o,
    output logic        irq_error_o
);

    logic [31:0] r_cstart, r_hstartl, r_hstarth, r_len, r_nextl, r_nexth, r_attrib;
    logic        start_req, abort_req, clr_req;
    logic        wb_req, wb_wr, cfg_locked;
    logic [31:0] rd_mux;
    t_dma_state  state;

    // ~ack keeps a held strobe from being accepted twice.
    assign wb_req     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wb_wr      = wb_req & wb_we_i;
    assign cfg_locked = (state == BUSY) || (state == ABORTING);

    always_comb begin
        rd_mux = '0;
        case (wb_adr_i)
            c_DMA_STATUS:  rd_mux = {29'd0, status_code(state)};
            c_DMA_CSTART:  rd_mux = r_cstart;
            c_DMA_HSTARTL: rd_mux = r_hstartl;
            c_DMA_HSTARTH: rd_mux = r_hstarth;
            c_DMA_LEN:     rd_mux = r_len;
            c_DMA_NEXTL:   rd_mux = r_nextl;
            c_DMA_NEXTH:   rd_mux = r_nexth;
            c_DMA_ATTRIB:  rd_mux = r_attrib;
            default:       rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wb_ack_o  <= 1'b0;
            wb_dat_o  <= '0;
            start_req <= 1'b0;
            abort_req <= 1'b0;
            clr_req   <= 1'b0;
            r_cstart  <= '0;
            r_hstartl <= '0;
            r_hstarth <= '0;
            r_len     <= '0;
            r_nextl   <= '0;
            r_nexth   <= '0;
            r_attrib  <= '0;
        end else begin
            wb_ack_o  <= wb_req;
            wb_dat_o  <= (wb_req && !wb_we_i) ? rd_mux : '0;
            start_req <= wb_wr && (wb_adr_i == c_DMA_CTRL) && wb_dat_i[c_CTRL_START_BIT];
            abort_req <= wb_wr && (wb_adr_i == c_DMA_CTRL) && wb_dat_i[c_CTRL_ABORT_BIT];
            clr_req   <= wb_wr && (wb_adr_i == c_DMA_STATUS)
                      && ((wb_dat_i & c_STATUS_CLR_MASK) != '0);
            if (wb_wr && !cfg_locked) begin
                case (wb_adr_i)
                    c_DMA_CSTART:  r_cstart  <= wb_dat_i;
                    c_DMA_HSTARTL: r_hstartl <= wb_dat_i;
                    c_DMA_HSTARTH: r_hstarth <= wb_dat_i;
                    c_DMA_LEN:     r_len     <= wb_dat_i;
                    c_DMA_NEXTL:   r_nextl   <= wb_dat_i;
                    c_DMA_NEXTH:   r_nexth   <= wb_dat_i;
                    c_DMA_ATTRIB:  r_attrib  <= wb_dat_i;
                    default: ;
                endcase
            end
        end
    end

    assign xfer_dir_o          = r_attrib[c_ATTRIB_DIR_BIT];
    assign xfer_carrier_addr_o = r_cstart;
    assign xfer_host_addr_o    = {r_hstarth, r_hstartl};
    assign xfer_len_o          = r_len;
    assign xfer_next_o         = {r_nexth, r_nextl};

    dma_ctrl_fsm #(
        .g_TIMEOUT    (g_TIMEOUT),
        .g_ADDR_ALIGN (g_ADDR_ALIGN)
    ) u_fsm (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .start_req    (start_req),
        .abort_req    (abort_req),
        .clr_req      (clr_req),
        .cstart       (r_cstart),
        .len          (r_len),
        .xfer_done_i  (xfer_done_i),
        .xfer_error_i (xfer_error_i),
        .state        (state),
        .xfer_start   (xfer_start_o),
        .xfer_abort   (xfer_abort_o),
        .irq_done     (irq_done_o),
        .irq_error    (irq_error_o)
    );

endmodule

// File: tb/tb_dma_ctrl_regs.sv
// tb_dma_ctrl_regs
//   Directed bench for dma_ctrl_regs with hand-computed expectations.
//   Inputs change on the falling edge, outputs are sampled on the falling edge.
module tb_dma_ctrl_regs;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
    logic [3:0]  wb_adr_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        xfer_start_o, xfer_dir_o, xfer_abort_o;
    logic [31:0] xfer_carrier_addr_o, xfer_len_o;
    logic [63:0] xfer_host_addr_o, xfer_next_o;
    logic        xfer_done_i = 1'b0, xfer_error_i = 1'b0;
    logic        irq_done_o, irq_error_o;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk_i = ~clk_i;

    dma_ctrl_regs #(
        .g_TIMEOUT    (100),
        .g_ADDR_ALIGN (4)
    ) dut (
        .clk_i               (clk_i),
        .rst_n_i             (rst_n_i),
        .wb_cyc_i            (wb_cyc_i),
        .wb_stb_i            (wb_stb_i),
        .wb_we_i             (wb_we_i),
        .wb_adr_i            (wb_adr_i),
        .wb_dat_i            (wb_dat_i),
        .wb_dat_o            (wb_dat_o),
        .wb_ack_o            (wb_ack_o),
        .xfer_start_o        (xfer_start_o),
        .xfer_dir_o          (xfer_dir_o),
        .xfer_carrier_addr_o (xfer_carrier_addr_o),
        .xfer_host_addr_o    (xfer_host_addr_o),
        .xfer_len_o          (xfer_len_o),
        .xfer_next_o         (xfer_next_o),
        .xfer_abort_o        (xfer_abort_o),
        .xfer_done_i         (xfer_done_i),
        .xfer_error_i        (xfer_error_i),
        .irq_done_o          (irq_done_o),
        .irq_error_o         (irq_error_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Returns on the falling edge of the ack cycle.
    task automatic wb_write(input logic [3:0] adr, input logic [31:0] dat);
        @(negedge clk_i);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = adr;  wb_dat_i = dat;
        @(negedge clk_i);
        chk("wr_ack", 64'(wb_ack_o), 64'd1);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    endtask

    task automatic wb_read(input logic [3:0] adr, output logic [31:0] dat);
        @(negedge clk_i);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
        wb_adr_i = adr;
        @(negedge clk_i);
        chk("rd_ack", 64'(wb_ack_o), 64'd1);
        dat = wb_dat_o;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] adr, input logic [31:0] exp);
        logic [31:0] d;
        wb_read(adr, d);
        chk(tag, 64'(d), 64'(exp));
    endtask

    // Bounded wait for the command pulse; leaves us on the pulse cycle.
    task automatic wait_start(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk_i);
            if (xfer_start_o) seen = 1'b1;
        end
        chk(tag, 64'(seen), 64'd1);
    endtask

    task automatic pulse_done(input logic d, input logic e);
        @(negedge clk_i);
        xfer_done_i = d; xfer_error_i = e;
        @(negedge clk_i);
        xfer_done_i = 1'b0; xfer_error_i = 1'b0;
    endtask

    initial begin
        int extra;
        bit early;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk_i);
        chk("rst_outs", {xfer_start_o, xfer_abort_o, irq_done_o, irq_error_o, wb_ack_o, xfer_dir_o}, 64'd0);
        chk("rst_len", 64'(xfer_len_o), 64'd0);
        rst_n_i = 1'b1;
        rd_chk("rst_status", 4'd1, 32'd0);

        // ---------------- happy WR ----------------
        wb_write(4'd2, 32'h100);
        wb_write(4'd3, 32'h2000_0000);
        wb_write(4'd4, 32'h0);
        wb_write(4'd5, 32'h80);
        wb_write(4'd6, 32'hDEAD_0000);
        wb_write(4'd7, 32'h1);
        wb_write(4'd8, 32'h1);
        wb_write(4'd9, 32'hFFFF_FFFF);
        rd_chk("unmapped_rd", 4'd9, 32'd0);
        rd_chk("attrib_rd", 4'd8, 32'd1);
        wb_write(4'd0, 32'h1);
        chk("start_not_in_ack", 64'(xfer_start_o), 64'd0);
        @(negedge clk_i);
        chk("start_pulse", 64'(xfer_start_o), 64'd1);
        chk("dir_wr", 64'(xfer_dir_o), 64'd1);
        chk("len_out", 64'(xfer_len_o), 64'h80);
        chk("caddr_out", 64'(xfer_carrier_addr_o), 64'h100);
        chk("haddr_out", xfer_host_addr_o, 64'h0000_0000_2000_0000);
        chk("next_out", xfer_next_o, 64'h0000_0001_DEAD_0000);
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            extra += int'(xfer_start_o);
        end
        chk("single_pulse", 64'(extra), 64'd0);
        rd_chk("status_busy", 4'd1, 32'd2);
        rd_chk("ctrl_rd0", 4'd0, 32'd0);
        repeat (33) @(negedge clk_i);
        pulse_done(1'b1, 1'b0);
        chk("irq_done_set", {irq_done_o, irq_error_o}, 64'b10);
        rd_chk("status_done", 4'd1, 32'd1);
        wb_write(4'd1, 32'h4);
        @(negedge clk_i);
        chk("irq_done_clr", 64'(irq_done_o), 64'd0);
        rd_chk("status_idle", 4'd1, 32'd0);

        // ---------------- bad config ----------------
        wb_write(4'd5, 32'h7E);
        wb_write(4'd0, 32'h1);
        @(negedge clk_i);
        chk("bad_len_nostart", 64'(xfer_start_o), 64'd0);
        chk("bad_len_irq", 64'(irq_error_o), 64'd1);
        rd_chk("bad_len_status", 4'd1, 32'd3);
        wb_write(4'd1, 32'h4);
        wb_write(4'd5, 32'h0);
        wb_write(4'd0, 32'h1);
        @(negedge clk_i);
        chk("zero_len_nostart", 64'(xfer_start_o), 64'd0);
        chk("zero_len_irq", 64'(irq_error_o), 64'd1);
        rd_chk("zero_len_status", 4'd1, 32'd3);
        wb_write(4'd1, 32'h4);
        wb_write(4'd5, 32'h80);
        wb_write(4'd2, 32'h102);
        wb_write(4'd0, 32'h1);
        @(negedge clk_i);
        chk("bad_caddr_nostart", 64'(xfer_start_o), 64'd0);
        rd_chk("bad_caddr_status", 4'd1, 32'd3);
        wb_write(4'd1, 32'h4);
        rd_chk("clr_to_idle", 4'd1, 32'd0);

        // ---------------- abort ----------------
        wb_write(4'd2, 32'h100);
        wb_write(4'd5, 32'h1000);
        wb_write(4'd8, 32'h0);
        wb_write(4'd0, 32'h3);               // start+abort together: start wins
        wait_start("abort_start");
        chk("dir_rd", 64'(xfer_dir_o), 64'd0);
        chk("no_abort_at_start", 64'(xfer_abort_o), 64'd0);
        repeat (10) @(negedge clk_i);
        wb_write(4'd0, 32'h2);
        @(negedge clk_i);
        chk("abort_level", 64'(xfer_abort_o), 64'd1);
        rd_chk("aborting_status", 4'd1, 32'd2);
        repeat (20) @(negedge clk_i);
        chk("abort_held", 64'(xfer_abort_o), 64'd1);
        pulse_done(1'b1, 1'b0);
        chk("abort_dropped", 64'(xfer_abort_o), 64'd0);
        chk("abort_irqs", {irq_done_o, irq_error_o}, 64'b01);
        rd_chk("aborted_status", 4'd1, 32'd4);
        wb_write(4'd1, 32'h4);

        // ---------------- timeout ----------------
        wb_write(4'd5, 32'h80);
        wb_write(4'd0, 32'h1);
        wait_start("tmo_start");
        early = 1'b0;
        for (int i = 1; i < 100; i++) begin
            @(negedge clk_i);
            if (xfer_abort_o || irq_error_o) early = 1'b1;
        end
        chk("tmo_not_early", 64'(early), 64'd0);
        @(negedge clk_i);
        chk("tmo_at_100", {xfer_abort_o, irq_error_o}, 64'b11);
        @(negedge clk_i);
        chk("tmo_abort_1cyc", 64'(xfer_abort_o), 64'd0);
        rd_chk("tmo_status", 4'd1, 32'd3);

        // ---------------- lock / collision ----------------
        wb_write(4'd0, 32'h1);               // restart directly from ERROR
        wait_start("lock_start");
        chk("restart_clears_irq", 64'(irq_error_o), 64'd0);
        wb_write(4'd5, 32'h40);
        rd_chk("len_locked", 4'd5, 32'h80);
        chk("len_out_locked", 64'(xfer_len_o), 64'h80);
        pulse_done(1'b1, 1'b1);
        chk("collide_irqs", {irq_done_o, irq_error_o}, 64'b01);
        rd_chk("collide_status", 4'd1, 32'd3);
        wb_write(4'd0, 32'h1);
        wait_start("clr_start");
        repeat (3) @(negedge clk_i);
        wb_write(4'd1, 32'h4);
        xfer_done_i = 1'b1;                  // lands on the same edge as the clear
        @(negedge clk_i);
        xfer_done_i = 1'b0;
        chk("clr_vs_done", 64'(irq_done_o), 64'd1);
        rd_chk("clr_vs_done_status", 4'd1, 32'd1);
        wb_write(4'd1, 32'h4);

        // ---------------- reset mid-BUSY ----------------
        wb_write(4'd0, 32'h1);
        wait_start("rst_start");
        repeat (4) @(negedge clk_i);
        #2 rst_n_i = 1'b0;
        #1;
        chk("arst_ctl", {xfer_start_o, xfer_abort_o, irq_done_o, irq_error_o, wb_ack_o, xfer_dir_o}, 64'd0);
        chk("arst_len", 64'(xfer_len_o), 64'd0);
        chk("arst_caddr", 64'(xfer_carrier_addr_o), 64'd0);
        chk("arst_haddr", xfer_host_addr_o, 64'd0);
        chk("arst_next", xfer_next_o, 64'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        rd_chk("post_rst_status", 4'd1, 32'd0);
        for (int a = 2; a <= 8; a++) begin
            rd_chk("post_rst_reg", 4'(a), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

endmodule

// File: doc/dma_ctrl_regs.md
Name: dma_ctrl_regs

Overview:
- Carrier-side register front-end and sequencer for the GN4124 DMA path.
- Sits on the system Wishbone bus at DMA_BASE (0x00C0). It accepts the host's programming writes: start, status-clear, addresses, length and attrib.
- Issues one transfer command to the DMA data mover, tracks completion, abort and timeout, and drives the done/error interrupt lines into the VIC. The done line is VIC input 2.

Parameters:
- g_TIMEOUT, 2**20, cycles allowed in BUSY before a forced error; 0 disables the timeout.
- g_ADDR_ALIGN, 4, required byte alignment of carrier address and length.

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  asynchronous active-low reset
- wb_cyc_i  in  1  Wishbone cycle
- wb_stb_i  in  1  Wishbone strobe
- wb_we_i  in  1  write enable
- wb_adr_i  in  4  word address (byte offset/4)
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  read data
- wb_ack_o  out  1  acknowledge
- xfer_start_o  out  1  one-cycle command pulse to mover
- xfer_dir_o  out  1  0 = carrier->host (RD), 1 = host->carrier (WR)
- xfer_carrier_addr_o  out  32  carrier byte address
- xfer_host_addr_o  out  64  host byte address {hi,lo}
- xfer_len_o  out  32  length in bytes
- xfer_next_o  out  64  next-descriptor pointer, passed through
- xfer_abort_o  out  1  level, held until mover reports done
- xfer_done_i  in  1  one-cycle completion pulse from mover
- xfer_error_i  in  1  one-cycle error pulse from mover
- irq_done_o  out  1  level interrupt, transfer complete
- irq_error_o  out  1  level interrupt, error or abort

Behaviour:
Register map (word offsets):
- 0 CTRL (W): bit0 start, bit1 abort. Reads return 0.
- 1 STATUS: R[2:0] state code (0 IDLE, 1 DONE, 2 BUSY, 3 ERROR, 4 ABORTED). W bit2 = 1 clears both irqs and returns DONE/ERROR/ABORTED to IDLE.
- 2 CSTART, 3 HSTARTL, 4 HSTARTH, 5 LEN, 6 NEXTL, 7 NEXTH: 32-bit RW.
- 8 ATTRIB: bit0 dir, other bits RW-stored and ignored.
- Offsets 9..15: read 0, writes ignored, ack still given.

Wishbone:
- Classic single-cycle: wb_ack_o is asserted the cycle after cyc&stb is sampled, for one cycle.
- Read data is valid with ack.
- No stall, no error.

Config lock:
- Writes to offsets 2..8 while BUSY are acked and discarded.
- Outputs xfer_* mirror the registers combinationally from flops.

FSM:
- IDLE/DONE/ERROR/ABORTED + start:
  - If LEN==0, or LEN or CSTART is not a multiple of g_ADDR_ALIGN: go to ERROR and set irq_error_o. No xfer_start_o.
  - Otherwise: xfer_start_o=1 the cycle after the write ack, go to BUSY, clear both irqs, load timeout counter.
- BUSY:
  - xfer_done_i: go to DONE, irq_done_o=1.
  - xfer_error_i: go to ERROR, irq_error_o=1. error wins if coincident with done.
  - abort: xfer_abort_o=1, go to ABORTING (code 2 reported). Start writes are ignored while BUSY.
  - Timeout counter reaches 0: go to ERROR, irq_error_o=1, pulse xfer_abort_o for one cycle.
- ABORTING: on xfer_done_i or xfer_error_i, drop xfer_abort_o, go to ABORTED, irq_error_o=1.
- A STATUS-clear in the same cycle as a new irq event: the event wins, so the irq stays set.
- A STATUS-clear while BUSY/ABORTING clears only the irq flops; the state is unchanged.
- start and abort set together in IDLE: abort ignored, start processed.

Reset values:
- All registers 0, state IDLE.
- All outputs 0.
- wb_ack_o 0.

Reset asserted mid-transfer:
- Immediate return to IDLE; outputs drop asynchronously.
- Mover is expected to share the reset.

Timeout counter:
- 32-bit down-counter; saturates at 0.

Decomposition:
- Package dma_ctrl_pkg holds:
  - register offset constants (c_DMA_CTRL=0 … c_DMA_ATTRIB=8);
  - CTRL/STATUS bit indices;
  - enum t_dma_state {IDLE, DONE, BUSY, ERROR, ABORTED, ABORTING} with 3-bit status encodings;
  - STATUS clear mask 0x4.
- One natural sub-module: dma_ctrl_fsm, holding the state machine, timeout counter and irq flops. The top keeps the Wishbone decode and register file.

Test Plan:
- Happy WR: program CSTART=0x100, HSTART=0x20000000, LEN=0x80, ATTRIB=1, CTRL=1 -> one xfer_start_o pulse, dir=1, len=0x80, STATUS=2. Mover done after 50 cycles -> irq_done_o=1, STATUS=1. Write STATUS=0x4 -> irq low, STATUS=0.
- Bad config: LEN=0x7E, CTRL=1 -> no xfer_start_o, STATUS=3, irq_error_o=1. Repeat with LEN=0 -> same.
- Abort: start a 0x1000-byte RD, CTRL=2 after 10 cycles -> xfer_abort_o=1 until done_i. Then STATUS=4, irq_error_o=1, irq_done_o=0.
- Timeout: g_TIMEOUT=100, mover never responds -> ERROR exactly 100 cycles after xfer_start_o, plus a one-cycle xfer_abort_o pulse.
- Lock/collision: write LEN=0x40 during BUSY -> readback keeps the old 0x80. done_i and error_i in the same cycle -> ERROR. STATUS clear coincident with done_i -> irq_done_o stays 1.
- Reset mid-BUSY: deassert rst_n_i asynchronously -> all outputs 0 within the same cycle, registers read 0 after release.
